// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered ALU between two requesters with round-robin
// arbitration. Each granted operation is driven onto the registered ALU
// inputs and held for the ALU latency. The result is then captured, and a
// one-cycle ack goes back to the granted requester.
// ALU control codes the ALU does not implement are not issued. They complete
// at once with err=1 and result=0.
// zero is derived from the captured result, so the ALU's own Zero output is
// not needed.
//
// Optional feature (macro ALU_ARBITER_ZERO_CHECK_EN): adds a sticky
// zero_mismatch output. It flags a SUB whose alu_zero disagrees with
// alu_saida==0 at the capture edge. Only reset clears it.
//
// Parameters:
//   ALU_LAT : clock edges from the ALU sampling its inputs to a stable output (1..7)
//   WIDTH   : operand/result width
// Ports:
//   clock, reset              : system clock, asynchronous active-high reset
//   req0/ctrl0/a0/b0          : requester 0 request, control code, operands
//   req1/ctrl1/a1/b1          : requester 1 request, control code, operands
//   ack0/ack1                 : one-cycle completion pulses
//   result/zero/err           : captured outcome, valid with ack, held otherwise
//   busy                      : high whenever the arbiter is not idle
//   alu_control/alu_in1/alu_in2 : registered drive to the shared ALU
//   alu_saida/alu_zero        : ALU result and Zero outputs
//   zero_mismatch             : (optional) sticky ALU Zero disagreement flag
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [3:0]       ctrl0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [3:0]       ctrl1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             busy,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_saida,
    input  logic             alu_zero
`ifdef ALU_ARBITER_ZERO_CHECK_EN
    ,
    output logic             zero_mismatch
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    // ALU_LAT is limited to 1..7, so a 3-bit counter reaches it
    localparam logic [2:0] LAT_C = 3'(ALU_LAT);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    function automatic logic ctrl_supported(input logic [3:0] code);
        logic ok;
        case (code)
            CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]       state_r;
    logic             last_grant_r;
    logic             grant_r;
    logic [2:0]       cnt_r;
    logic             ack0_r;
    logic             ack1_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             err_r;
    logic             busy_r;
    logic [3:0]       alu_control_r;
    logic [WIDTH-1:0] alu_in1_r;
    logic [WIDTH-1:0] alu_in2_r;

    logic             gnt_s;
    logic             any_req_s;
    logic             sel_ok_s;
    logic             capture_s;
    logic [3:0]       sel_ctrl_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    // Round-robin grant: on a tie the requester that did not win last time goes first
    always_comb begin
        gnt_s      = 1'b0;
        sel_ctrl_s = ctrl0;
        sel_a_s    = a0;
        sel_b_s    = b0;
        if (req0 && req1) begin
            gnt_s = ~last_grant_r;
        end else if (req1) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        if (gnt_s) begin
            sel_ctrl_s = ctrl1;
            sel_a_s    = a1;
            sel_b_s    = b1;
        end else begin
            sel_ctrl_s = ctrl0;
            sel_a_s    = a0;
            sel_b_s    = b0;
        end
    end

    assign any_req_s = req0 | req1;
    assign sel_ok_s  = ctrl_supported(sel_ctrl_s);
    assign capture_s = (state_r == ST_ISSUE) && (cnt_r == LAT_C);

    // Operation sequencer: grant in IDLE, wait out the ALU latency in ISSUE, ack in DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 1'b1;
            grant_r       <= 1'b0;
            cnt_r         <= 3'd0;
            ack0_r        <= 1'b0;
            ack1_r        <= 1'b0;
            result_r      <= ZERO_W;
            zero_r        <= 1'b0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
            alu_control_r <= 4'd0;
            alu_in1_r     <= ZERO_W;
            alu_in2_r     <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r      <= gnt_s;
                        last_grant_r <= gnt_s;
                        busy_r       <= 1'b1;
                        if (sel_ok_s) begin
                            alu_control_r <= sel_ctrl_s;
                            alu_in1_r     <= sel_a_s;
                            alu_in2_r     <= sel_b_s;
                            cnt_r         <= 3'd0;
                            state_r       <= ST_ISSUE;
                        end else begin
                            // Unsupported code never reaches the ALU; the alu_* drive is left untouched
                            result_r <= ZERO_W;
                            zero_r   <= 1'b0;
                            err_r    <= 1'b1;
                            ack0_r   <= ~gnt_s;
                            ack1_r   <= gnt_s;
                            state_r  <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= cnt_r + 3'd1;
                    if (capture_s) begin
                        result_r <= alu_saida;
                        zero_r   <= (alu_control_r == CTRL_SUB) && (alu_saida == ZERO_W);
                        err_r    <= 1'b0;
                        ack0_r   <= ~grant_r;
                        ack1_r   <= grant_r;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0        = ack0_r;
    assign ack1        = ack1_r;
    assign result      = result_r;
    assign zero        = zero_r;
    assign err         = err_r;
    assign busy        = busy_r;
    assign alu_control = alu_control_r;
    assign alu_in1     = alu_in1_r;
    assign alu_in2     = alu_in2_r;

`ifdef ALU_ARBITER_ZERO_CHECK_EN
    logic zero_mismatch_r;

    // Sticky flag: ALU Zero disagreed with the SUB result at capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_mismatch_r <= 1'b0;
        end else if (capture_s && (alu_control_r == CTRL_SUB) &&
                     (alu_zero != (alu_saida == ZERO_W))) begin
            zero_mismatch_r <= 1'b1;
        end else begin
            zero_mismatch_r <= zero_mismatch_r;
        end
    end

    assign zero_mismatch = zero_mismatch_r;
`else
    logic unused_alu_zero_s;
    assign unused_alu_zero_s = alu_zero;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A registered ALU with ALU_LAT edges of
// latency sits behind the DUT. The expected outcomes come from the arbitration
// and arithmetic rules: which requester wins, how many cycles the op takes, and
// the result, zero and err it returns. Directed cases run first, then a
// randomized phase.
module tb_alu_arbiter;

    localparam int ALU_LAT = 1;
    localparam int WIDTH   = 32;
    localparam int LAT_SUP = ALU_LAT + 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [3:0]       ctrl0, ctrl1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             ack0, ack1, zero, err, busy;
    logic [WIDTH-1:0] result, alu_in1, alu_in2, alu_saida;
    logic [3:0]       alu_control;
    logic             alu_zero;
    logic             zero_bad;
`ifdef ALU_ARBITER_ZERO_CHECK_EN
    logic             zero_mismatch;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic             model_last;
    logic [3:0]       exp_ctrl;
    logic [WIDTH-1:0] exp_in1, exp_in2;
    int               last_max_low;

    always #5 clock = ~clock;

    alu_arbiter #(.ALU_LAT(ALU_LAT), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .ctrl0(ctrl0), .a0(a0), .b0(b0),
        .req1(req1), .ctrl1(ctrl1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .zero(zero), .err(err), .busy(busy),
        .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_saida(alu_saida), .alu_zero(alu_zero)
`ifdef ALU_ARBITER_ZERO_CHECK_EN
        , .zero_mismatch(zero_mismatch)
`endif
    );

    // External ALU: garbage for codes it does not implement
    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            default: return x ^ y ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    logic [WIDTH-1:0] alu_pipe [ALU_LAT];
    always @(posedge clock) begin
        alu_pipe[0] <= alu_fn(alu_control, alu_in1, alu_in2);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_saida = alu_pipe[ALU_LAT-1];
    assign alu_zero  = (alu_saida == 32'd0) ^ zero_bad;

    function automatic logic is_sup(input logic [3:0] c);
        return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6);
    endfunction

    function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (c == 4'd0) return x & y;
        if (c == 4'd1) return x | y;
        if (c == 4'd2) return x + y;
        if (c == 4'd6) return x - y;
        return 32'd0;
    endfunction

    function automatic int op_cycles(input logic [3:0] c);
        return is_sup(c) ? LAT_SUP : 1;
    endfunction

    function automatic logic [3:0] pick_ctrl();
        case ($urandom_range(5, 0))
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0010;
            3, 4:    return 4'b0110;
            default: return {1'b1, 3'($urandom_range(7, 0))};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(output int cycles, output logic which, output logic got, output int max_low);
        int low;
        low = 0; cycles = 0; which = 1'b0; got = 1'b0; max_low = 0;
        while (!got && cycles < 40) begin
            tick();
            cycles++;
            if (ack0 || ack1) begin
                got   = 1'b1;
                which = ack1;
            end
            if (!busy) begin
                low++;
                if (low > max_low) max_low = low;
            end else begin
                low = 0;
            end
        end
    endtask

    // Waits for one completion and compares it against the rule-derived outcome
    task automatic expect_op(input string tag, input logic exp_which, input int exp_cycles,
                             input logic [3:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int cyc, ml;
        logic which, got;
        logic [WIDTH-1:0] r;
        wait_ack(cyc, which, got, ml);
        check({tag, ".ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            r = ref_result(c, x, y);
            if (is_sup(c)) begin
                exp_ctrl = c; exp_in1 = x; exp_in2 = y;
            end
            check({tag, ".which"},   32'(which), 32'(exp_which));
            check({tag, ".onehot"},  32'(ack0 ^ ack1), 32'd1);
            check({tag, ".latency"}, 32'(cyc), 32'(exp_cycles));
            check({tag, ".result"},  result, r);
            check({tag, ".zero"},    32'(zero), 32'((c == 4'd6) && (r == 32'd0)));
            check({tag, ".err"},     32'(err), 32'(!is_sup(c)));
            check({tag, ".busy"},    32'(busy), 32'd1);
            check({tag, ".alu_ctl"}, 32'(alu_control), 32'(exp_ctrl));
            check({tag, ".alu_in1"}, alu_in1, exp_in1);
            check({tag, ".alu_in2"}, alu_in2, exp_in2);
        end
        model_last   = exp_which;
        last_max_low = ml;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ack0"},   32'(ack0), 32'd0);
        check({tag, ".ack1"},   32'(ack1), 32'd0);
        check({tag, ".result"}, result, 32'd0);
        check({tag, ".zero"},   32'(zero), 32'd0);
        check({tag, ".err"},    32'(err), 32'd0);
        check({tag, ".busy"},   32'(busy), 32'd0);
        check({tag, ".alu_ctl"}, 32'(alu_control), 32'd0);
        check({tag, ".alu_in1"}, alu_in1, 32'd0);
        check({tag, ".alu_in2"}, alu_in2, 32'd0);
    endtask

    task automatic model_reset();
        model_last = 1'b1;
        exp_ctrl   = 4'd0;
        exp_in1    = 32'd0;
        exp_in2    = 32'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic first;
        int   pat, gap;

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; zero_bad = 1'b0;
        ctrl0 = 4'd0; ctrl1 = 4'd0; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
`ifdef ALU_ARBITER_ZERO_CHECK_EN
        check("reset.zm", 32'(zero_mismatch), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // ADD on requester 0
        ctrl0 = 4'b0010; a0 = 32'd5; b0 = 32'd7; req0 = 1'b1;
        expect_op("add0", 1'b0, LAT_SUP, ctrl0, a0, b0);
        check("add0.lit", result, 32'd12);
        req0 = 1'b0;
        tick();

        // SUB on requester 1, equal then off-by-one operands
        ctrl1 = 4'b0110; a1 = 32'h1234; b1 = 32'h1234; req1 = 1'b1;
        expect_op("sub_eq", 1'b1, LAT_SUP, ctrl1, a1, b1);
        check("sub_eq.zero_lit", 32'(zero), 32'd1);
        req1 = 1'b0;
        tick();
        b1 = 32'h1235; req1 = 1'b1;
        expect_op("sub_ne", 1'b1, LAT_SUP, ctrl1, a1, b1);
        check("sub_ne.lit", result, 32'hFFFF_FFFF);
        req1 = 1'b0;
        tick();

        // Both requesting continuously: strict alternation
        ctrl0 = 4'b0000; a0 = $urandom; b0 = $urandom;
        ctrl1 = 4'b0001; a1 = $urandom; b1 = $urandom;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            first = ~model_last;
            if (first == 1'b0) expect_op("b2b", 1'b0, (k == 0) ? LAT_SUP : LAT_SUP + 1, ctrl0, a0, b0);
            else               expect_op("b2b", 1'b1, (k == 0) ? LAT_SUP : LAT_SUP + 1, ctrl1, a1, b1);
            check("b2b.order", 32'(first), 32'(k % 2));
            check("b2b.busy_gap", 32'(last_max_low), (k == 0) ? 32'd0 : 32'd1);
            if (first == 1'b0) begin
                ctrl0 = 4'($urandom_range(1, 0)); a0 = $urandom; b0 = $urandom;
            end else begin
                ctrl1 = 4'($urandom_range(1, 0)); a1 = $urandom; b1 = $urandom;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Unsupported code completes immediately with err and no ALU issue
        ctrl0 = 4'b0111; a0 = $urandom; b0 = $urandom; req0 = 1'b1;
        expect_op("unsup", 1'b0, 1, ctrl0, a0, b0);
        check("unsup.err_lit", 32'(err), 32'd1);
        req0 = 1'b0;
        tick();

        // Reset while an op is in flight
        ctrl0 = 4'b0010; a0 = $urandom; b0 = $urandom; req0 = 1'b1;
        tick();
        check("rst_mid.busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all_zero("rst_mid");
        tick();
        tick();
        check("rst_hold.ack0", 32'(ack0), 32'd0);
`ifdef ALU_ARBITER_ZERO_CHECK_EN
        check("rst_hold.zm", 32'(zero_mismatch), 32'd0);
`endif
        ctrl0 = 4'b0001; a0 = $urandom; b0 = $urandom;
        reset = 1'b0;
        expect_op("post_rst", 1'b0, LAT_SUP, ctrl0, a0, b0);
        req0 = 1'b0;
        tick();

`ifdef ALU_ARBITER_ZERO_CHECK_EN
        // Wrong ALU Zero on a SUB sets the sticky flag
        zero_bad = 1'b1;
        ctrl0 = 4'b0110; a0 = $urandom; b0 = a0; req0 = 1'b1;
        expect_op("zm_sub", 1'b0, LAT_SUP, ctrl0, a0, b0);
        check("zm_sub.flag", 32'(zero_mismatch), 32'd1);
        req0 = 1'b0; zero_bad = 1'b0;
        tick();
        ctrl0 = 4'b0010; a0 = $urandom; b0 = $urandom; req0 = 1'b1;
        expect_op("zm_hold", 1'b0, LAT_SUP, ctrl0, a0, b0);
        check("zm_hold.flag", 32'(zero_mismatch), 32'd1);
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        check("zm_rst.flag", 32'(zero_mismatch), 32'd0);
        tick();
        reset = 1'b0;
        tick();
`endif

        // Randomized mix of single and contended requests
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(2, 0);
            ctrl0 = pick_ctrl(); a0 = $urandom; b0 = ($urandom_range(3, 0) == 0) ? a0 : $urandom;
            ctrl1 = pick_ctrl(); a1 = $urandom; b1 = ($urandom_range(3, 0) == 0) ? a1 : $urandom;
            req0 = (pat != 1);
            req1 = (pat != 0);
            first = (pat == 2) ? ~model_last : (pat == 1);
            if (first == 1'b0) begin
                expect_op("rnd", 1'b0, op_cycles(ctrl0), ctrl0, a0, b0);
                req0 = 1'b0;
            end else begin
                expect_op("rnd", 1'b1, op_cycles(ctrl1), ctrl1, a1, b1);
                req1 = 1'b0;
            end
            if (pat == 2) begin
                if (first == 1'b0) expect_op("rnd2", 1'b1, op_cycles(ctrl1) + 1, ctrl1, a1, b1);
                else               expect_op("rnd2", 1'b0, op_cycles(ctrl0) + 1, ctrl0, a0, b0);
                req0 = 1'b0; req1 = 1'b0;
            end
            gap = $urandom_range(2, 1);
            for (int g = 0; g < gap; g++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
